// File: rtl/seq_prio_enc_pkg.sv
// Shared types and helpers for seq_prio_encoder: FSM state encoding, popcount
// and a direction-selectable priority index over a zero-extended vector.
package seq_prio_enc_pkg;

    typedef logic [0:0] state_t;

    localparam state_t IDLE = 1'b0;
    localparam state_t BUSY = 1'b1;

    // Widest request vector the helpers support; callers zero-extend into this.
    localparam int MAX_N = 256;

    function automatic int popcount(input logic [MAX_N-1:0] vec);
        int cnt;
        cnt = 0;
        for (int i = 0; i < MAX_N; i++) begin
            if (vec[i]) cnt++;
        end
        return cnt;
    endfunction

    // Index of the lowest set bit, or the highest when msb_first is set; 0 for an empty vector.
    function automatic int prio_index(input logic [MAX_N-1:0] vec, input logic msb_first);
        int idx;
        idx = 0;
        if (msb_first) begin
            for (int i = 0; i < MAX_N; i++) begin
                if (vec[i]) idx = i;
            end
        end else begin
            for (int i = MAX_N - 1; i >= 0; i--) begin
                if (vec[i]) idx = i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/seq_prio_encoder_prio_idx.sv
// Combinational N-to-W priority encoder with a run-time direction select.
module prio_idx
    import seq_prio_enc_pkg::*;
#(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    input  logic         msb_first,
    output logic [W-1:0] idx
);

    logic [MAX_N-1:0] ext;
    int               sel;

    always_comb begin
        ext        = '0;
        ext[N-1:0] = vec;
        sel        = prio_index(ext, msb_first);
        idx        = W'(sel);
    end

endmodule

// File: rtl/seq_prio_encoder.sv
// Registered sequential priority encoder: stores a request vector and emits the index
// of each set bit in priority order. Optional zero-vector beat: SEQ_PRIO_ENC_ZERO_BEAT_EN.
module seq_prio_encoder
    import seq_prio_enc_pkg::*;
#(
    parameter int N         = 8,
    parameter int MSB_FIRST = 0,
    localparam int W        = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic         in_valid,
    input  logic [N-1:0] a,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_idx,
    output logic         out_last,
    output logic [W:0]   out_cnt
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
    ,
    output logic         out_zero
`endif
);

    state_t           state;
    logic [N-1:0]     pend;
    logic [N-1:0]     clr_mask;
    logic [MAX_N-1:0] a_ext;
    logic [MAX_N-1:0] pend_ext;
    int               a_pop;
    int               pend_pop;
    logic             accept;
    logic             beat;

    prio_idx #(.N(N)) u_prio_idx (
        .vec       (pend),
        .msb_first (MSB_FIRST != 0),
        .idx       (out_idx)
    );

    always_comb begin
        a_ext             = '0;
        a_ext[N-1:0]      = a;
        pend_ext          = '0;
        pend_ext[N-1:0]   = pend;
        a_pop             = popcount(a_ext);
        pend_pop          = popcount(pend_ext);
        clr_mask          = '0;
        clr_mask[out_idx] = 1'b1;
    end

    // Holding rst and flush out of in_ready keeps an upstream producer from seeing a false accept.
    assign in_ready  = (state == IDLE) && en && !flush && !rst;
    assign out_valid = (state == BUSY);
    assign accept    = in_valid && in_ready;
    assign beat      = out_valid && out_ready;

`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
    logic pend_zero;
    assign pend_zero = (pend == '0);
    assign out_zero  = (state == BUSY) && pend_zero;
    assign out_last  = (state == BUSY) && ((pend_pop == 1) || pend_zero);
`else
    assign out_last  = (state == BUSY) && (pend_pop == 1);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            pend    <= '0;
            out_cnt <= '0;
        end else if (flush) begin
            state <= IDLE;
            pend  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        pend    <= a;
                        out_cnt <= (W+1)'(a_pop);
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
                        state   <= BUSY;
`else
                        if (a != '0) state <= BUSY;
`endif
                    end
                end
                BUSY: begin
                    if (beat) begin
                        pend <= pend & ~clr_mask;
                        if (out_last) state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_prio_encoder.sv
// Scoreboard bench for seq_prio_encoder: LSB-first and MSB-first instances share stimulus,
// each with its own expected-beat queue filled from a list-of-set-bits reference model.
module tb_seq_prio_encoder;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         flush;
    logic         in_valid;
    logic [N-1:0] a;
    logic         out_ready;

    logic         in_ready_lo, out_valid_lo, out_last_lo;
    logic [W-1:0] out_idx_lo;
    logic [W:0]   out_cnt_lo;
    logic         in_ready_hi, out_valid_hi, out_last_hi;
    logic [W-1:0] out_idx_hi;
    logic [W:0]   out_cnt_hi;
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
    logic         out_zero_lo, out_zero_hi;
`endif

    seq_prio_encoder #(.N(N), .MSB_FIRST(0)) u_lo (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .a(a),
        .in_ready(in_ready_lo), .out_valid(out_valid_lo), .out_ready(out_ready),
        .out_idx(out_idx_lo), .out_last(out_last_lo), .out_cnt(out_cnt_lo)
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
        , .out_zero(out_zero_lo)
`endif
    );

    seq_prio_encoder #(.N(N), .MSB_FIRST(1)) u_hi (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .in_valid(in_valid), .a(a),
        .in_ready(in_ready_hi), .out_valid(out_valid_hi), .out_ready(out_ready),
        .out_idx(out_idx_hi), .out_last(out_last_hi), .out_cnt(out_cnt_hi)
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
        , .out_zero(out_zero_hi)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        bit last;
        int cnt;
        bit zero;
    } beat_t;

    beat_t q_lo[$];
    beat_t q_hi[$];
    int    total = 0;
    int    bad   = 0;
    int    ready_mode = 0;
    bit    held[2];
    int    held_idx[2];
    int    held_last[2];

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: list the set bits low to high, then read the list forwards or backwards.
    task automatic applyModel(input logic [N-1:0] vec);
        int ids[$];
        int c;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) ids.push_back(i);
        end
        c = ids.size();
        if (c == 0) begin
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
            q_lo.push_back('{0, 1'b1, 0, 1'b1});
            q_hi.push_back('{0, 1'b1, 0, 1'b1});
`endif
        end else begin
            for (int k = 0; k < c; k++) begin
                q_lo.push_back('{ids[k], k == c - 1, c, 1'b0});
                q_hi.push_back('{ids[c - 1 - k], k == c - 1, c, 1'b0});
            end
        end
    endtask

    task automatic checkSide(input int s, input logic v, input logic [W-1:0] idx,
                             input logic last, input logic [W:0] cnt, input logic rdy
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
                             , input logic z
`endif
                             );
        beat_t e;
        bit    empty;
        string tag;
        tag = (s == 0) ? "lo" : "hi";
        if (held[s]) begin
            checkOutput({tag, " stall valid"}, int'(v), 1);
            checkOutput({tag, " stall idx"}, int'(idx), held_idx[s]);
            checkOutput({tag, " stall last"}, int'(last), held_last[s]);
        end
        if (v) begin
            checkOutput({tag, " in_ready while busy"}, int'(rdy), 0);
            if (out_ready) begin
                empty = (s == 0) ? (q_lo.size() == 0) : (q_hi.size() == 0);
                if (empty) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL %s unexpected beat: got idx %0d expected none at %0t", tag, idx, $time);
                end else begin
                    if (s == 0) e = q_lo.pop_front();
                    else        e = q_hi.pop_front();
                    checkOutput({tag, " idx"}, int'(idx), e.idx);
                    checkOutput({tag, " last"}, int'(last), int'(e.last));
                    checkOutput({tag, " cnt"}, int'(cnt), e.cnt);
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
                    checkOutput({tag, " zero"}, int'(z), int'(e.zero));
`endif
                end
            end
        end
        held[s]      = v && out_ready == 1'b0;
        held_idx[s]  = int'(idx);
        held_last[s] = int'(last);
    endtask

    // Monitor: samples mid-cycle; a flush cycle discards its handshake.
    always @(negedge clk) begin
        if (rst || flush) begin
            held[0] = 1'b0;
            held[1] = 1'b0;
        end else begin
            checkSide(0, out_valid_lo, out_idx_lo, out_last_lo, out_cnt_lo, in_ready_lo
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
                      , out_zero_lo
`endif
                      );
            checkSide(1, out_valid_hi, out_idx_hi, out_last_hi, out_cnt_hi, in_ready_hi
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
                      , out_zero_hi
`endif
                      );
        end
    end

    // Consumer: 0 always ready, 1 toggle, 2 random, 3 never ready.
    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (out_ready === 1'b1) ? 1'b0 : 1'b1;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int expBeats(input logic [N-1:0] vec);
        int c;
        c = $countones(vec);
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
        if (c == 0) c = 1;
`endif
        return c;
    endfunction

    // Called just after a rising edge; returns just after a rising edge with the block idle.
    task automatic applyStimulus(input logic [N-1:0] vec, input bit rand_en, output int acc_wait);
        int waited;
        bit done;
        a        = vec;
        in_valid = 1'b1;
        done     = 1'b0;
        waited   = 0;
        while (!done && waited < 50) begin
            @(negedge clk);
            if (in_ready_lo) begin
                checkOutput("in_ready lo/hi agree", int'(in_ready_hi), int'(in_ready_lo));
                applyModel(vec);
                done = 1'b1;
            end else begin
                waited++;
            end
            tick();
            if (!done && rand_en) en = ($urandom_range(0, 3) != 0);
        end
        in_valid = 1'b0;
        acc_wait = waited;
        if (!done) begin
            total++;
            bad++;
            $display("[TB] FAIL accept timeout: got no accept expected accept of %h", vec);
            return;
        end
        waited = 0;
        while (waited < 200) begin
            @(negedge clk);
            if (q_lo.size() == 0 && q_hi.size() == 0 && !out_valid_lo && !out_valid_hi) break;
            waited++;
        end
        if (waited >= 200) begin
            total++;
            bad++;
            $display("[TB] FAIL drain timeout: got %0d beats pending expected 0", q_lo.size());
        end else begin
            if (ready_mode == 0) checkOutput("drain cycles", waited, expBeats(vec));
            checkOutput("in_ready after drain", int'(in_ready_lo), int'(en));
        end
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int w;
        logic [N-1:0] rv;
        rst = 1'b1; en = 1'b1; flush = 1'b0; in_valid = 1'b0; a = '0; ready_mode = 0;
        @(negedge clk);
        checkOutput("reset in_ready", int'(in_ready_lo), 0);
        checkOutput("reset out_valid lo", int'(out_valid_lo), 0);
        checkOutput("reset out_valid hi", int'(out_valid_hi), 0);
        checkOutput("reset idx", int'(out_idx_lo), 0);
        checkOutput("reset last", int'(out_last_lo), 0);
        checkOutput("reset cnt", int'(out_cnt_lo), 0);
`ifdef SEQ_PRIO_ENC_ZERO_BEAT_EN
        checkOutput("reset zero", int'(out_zero_lo), 0);
`endif
        tick();
        rst = 1'b0;
        tick();

        applyStimulus(8'b1010_0100, 1'b0, w);
        checkOutput("cnt A4", int'(out_cnt_lo), 3);
        ready_mode = 1;
        tick();
        applyStimulus(8'hFF, 1'b0, w);
        checkOutput("cnt FF hi", int'(out_cnt_hi), 8);
        ready_mode = 0;
        tick();
        applyStimulus(8'b0001_0000, 1'b0, w);
        checkOutput("cnt one-hot", int'(out_cnt_lo), 1);

        en = 1'b0; in_valid = 1'b1; a = 8'h3C;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("en=0 in_ready", int'(in_ready_lo), 0);
            checkOutput("en=0 no accept", int'(out_valid_lo), 0);
            tick();
        end
        en = 1'b1;
        applyStimulus(8'h3C, 1'b0, w);
        checkOutput("accept on first en cycle", w, 0);

        a = 8'h81; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("flush test accept", int'(in_ready_lo), 1);
        applyModel(8'h81);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        tick();
        flush = 1'b1;
        q_lo.delete();
        q_hi.delete();
        @(negedge clk);
        tick();
        flush = 1'b0;
        @(negedge clk);
        checkOutput("flush out_valid lo", int'(out_valid_lo), 0);
        checkOutput("flush out_valid hi", int'(out_valid_hi), 0);
        checkOutput("flush in_ready", int'(in_ready_lo), 1);
        tick();
        @(negedge clk);
        checkOutput("flush no late beat", int'(out_valid_lo), 0);
        tick();
        flush = 1'b1; in_valid = 1'b1; a = 8'h0F;
        @(negedge clk);
        checkOutput("flush blocks in_ready", int'(in_ready_lo), 0);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checkOutput("flush suppressed accept", int'(out_valid_lo), 0);
        checkOutput("cnt kept after flush", int'(out_cnt_lo), 2);
        tick();

        ready_mode = 3;
        tick();
        a = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("rst test accept", int'(in_ready_lo), 1);
        applyModel(8'hFF);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async rst out_valid", int'(out_valid_lo | out_valid_hi), 0);
        checkOutput("async rst idx", int'(out_idx_hi), 0);
        checkOutput("async rst last", int'(out_last_hi), 0);
        checkOutput("async rst cnt", int'(out_cnt_lo), 0);
        checkOutput("async rst in_ready", int'(in_ready_lo), 0);
        q_lo.delete();
        q_hi.delete();
        @(negedge clk);
        tick();
        rst = 1'b0;
        ready_mode = 0;
        tick();

        applyStimulus('0, 1'b0, w);
        checkOutput("zero cnt", int'(out_cnt_lo), 0);

        ready_mode = 2;
        for (int t = 0; t < 40; t++) begin
            rv = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
            en = 1'b1;
            applyStimulus(rv, 1'b1, w);
            checkOutput("random cnt", int'(out_cnt_lo), $countones(rv));
        end

        checkOutput("queues empty at end", q_lo.size() + q_hi.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
